// File: rtl/uart_tx_frame_pkg.sv
// uart_pkg: state encoding and line/parity constants shared by the UART TX and RX paths.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PAR_EVEN    = 1'b0;
  localparam logic PAR_ODD     = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: host-side handshake and serial-line signals of the UART transmitter.
interface uart_tx_frame_if #(parameter int DATA_WIDTH = 8, parameter int PWIDTH = 6);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic [PWIDTH-1:0]     prescale;
  logic                  tx_out;
  logic                  busy;
  logic                  tx_done;
  modport master (output p_data, data_valid, par_en, par_typ, prescale, input tx_out, busy, tx_done);
  modport slave  (input p_data, data_valid, par_en, par_typ, prescale, output tx_out, busy, tx_done);
endinterface

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts clock edges within a bit and flags the last edge of each bit period.
module uart_tx_bit_timer #(parameter int PWIDTH = 6) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [PWIDTH-1:0] period,
  output logic              bit_end,
  output logic [PWIDTH-1:0] count
);
  assign bit_end = enable && count == period - PWIDTH'(1);
  // Every state change coincides with bit_end, so the wrap also restarts the count per state.
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else     count <= (!enable || bit_end) ? '0 : count + PWIDTH'(1);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises a byte as start, LSB-first data, optional parity and stop bits.
module uart_tx_frame
  import uart_pkg::*;
#(parameter int DATA_WIDTH = 8, parameter int PWIDTH = 6) (
  input logic             clk,
  input logic             rst,
  uart_tx_frame_if.slave  bus
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] shift, shift_next;
  logic [BW-1:0]         bit_cnt, bit_cnt_next;
  logic [PWIDTH-1:0]     period, edge_cnt;
  logic                  par_en_q, par_bit, tx_q, busy_q, done_q, tx_next;
  logic                  accept, bit_end, last_bit;

  assign accept       = !busy_q && bus.data_valid;
  assign last_bit     = bit_cnt == BW'(DATA_WIDTH - 1);
  assign shift_next   = accept ? bus.p_data : (state == DATA && bit_end) ? shift >> 1 : shift;
  assign bit_cnt_next = state_next != state ? '0 : (state == DATA && bit_end) ? bit_cnt + BW'(1) : bit_cnt;
  assign bus.tx_out   = tx_q;
  assign bus.busy     = busy_q;
  assign bus.tx_done  = done_q;

  uart_tx_bit_timer #(.PWIDTH(PWIDTH)) timer (
    .clk(clk), .rst(rst), .enable(state != IDLE), .period(period), .bit_end(bit_end), .count(edge_cnt)
  );

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      period   <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      tx_q     <= IDLE_LEVEL;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state   <= state_next;
      shift   <= shift_next;
      bit_cnt <= bit_cnt_next;
      tx_q    <= tx_next;
      busy_q  <= state_next != IDLE;
      done_q  <= state == STOP && state_next == IDLE;
      if (accept) begin
        period   <= bus.prescale == '0 ? PWIDTH'(1) : bus.prescale;
        par_en_q <= bus.par_en;
        par_bit  <= ^bus.p_data ^ (bus.par_typ == PAR_ODD);
      end
    end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? START : IDLE;
      START:   state_next = bit_end ? DATA : START;
      DATA:    state_next = !(bit_end && last_bit) ? DATA : par_en_q ? PARITY : STOP;
      PARITY:  state_next = bit_end ? STOP : PARITY;
      STOP:    state_next = bit_end ? IDLE : STOP;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the upcoming state so tx_out moves with the state change.
  always_comb
    tx_next = state_next == START  ? START_LEVEL :
              state_next == DATA   ? shift_next[0] :
              state_next == PARITY ? par_bit : IDLE_LEVEL;

  a_edge_in_period: assert property (@(posedge clk) disable iff (rst) state == IDLE || edge_cnt < period);
endmodule
